uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised serial receiver: oversampled start/data/parity/stop framing, 2-FF input sync,
//  false-start rejection, parity/framing error detection, received words buffered in a FIFO
//  with valid/ready pop handshake. Sits between the board serial pin and the character consumer.
// PARAMETERS
//  CLK_DIV     300  CLOCK_50 cycles per oversample tick (>=1)
//  OVERSAMPLE  16   ticks per bit period (even, >=4)
//  DATA_BITS   8    payload bits per character (5..9), LSB first on the line
//  PARITY      0    0 none, 1 even, 2 odd
//  STOP_BITS   1    1 or 2
//  FIFO_DEPTH  4    words buffered (power of 2, >=2)
// PORTS
//  CLOCK_50   in   1          system clock, all state on rising edge
//  reset      in   1          asynchronous, active-low
//  DataIn     in   1          serial line, idle high, asynchronous to CLOCK_50
//  DataReady  in   1          consumer accepts head word this cycle
//  DataOut    out  DATA_BITS  FIFO head word
//  DataValid  out  1          FIFO non-empty; DataOut/ParityErr/FrameErr valid
//  ParityErr  out  1          parity mismatch on head word (0 when PARITY==0)
//  FrameErr   out  1          a stop bit sampled low on head word
//  Overrun    out  1          sticky: a word was dropped because FIFO was full
//  Busy       out  1          receive FSM not in IDLE
// BEHAVIOUR
//  Reset (reset==0, async): sync flops=1, FSM=IDLE, counters=0, FIFO empty, all outputs 0.
//  Tick: divider counts 0..CLK_DIV-1; tick=1 for one cycle at CLK_DIV-1. Divider and sample
//   counter are cleared on start-edge detect so bit centres are phase-aligned to the edge.
//  Edge detect: synced line 1->0 while IDLE -> START (cycle after the synced falling edge).
//  FSM (sample counter sc counts ticks, bit counter bc):
//   IDLE   : wait for start edge.
//   START  : at sc==OVERSAMPLE/2-1 sample; high -> IDLE (glitch, nothing pushed);
//            low -> DATA, sc=0, bc=0.
//   DATA   : sample at sc==OVERSAMPLE-1 into shift reg (LSB first); bc==DATA_BITS-1 ->
//            PARITY if PARITY!=0 else STOP.
//   PARITY : sample one bit; err = (^data ^ bit) != (PARITY==2).
//   STOP   : sample STOP_BITS bits; any low sample sets frame flag. After last stop
//            sample: push {frame,parity,data}, go IDLE same cycle (next start edge may
//            follow immediately; line low at last stop sample does NOT re-arm until it
//            returns high and falls again).
//  Latency: word visible on DataOut with DataValid=1 one cycle after last stop sample
//   (FIFO empty case).
//  FIFO: pop when DataValid&&DataReady; DataOut shows next word (or holds, DataValid=0)
//   the following cycle. Push when full and no pop: word dropped, Overrun<=1.
//   Push and pop same cycle when full: both succeed, no overrun. Push+pop when empty:
//   push only visible next cycle (no bypass).
//  Overrun clears on the first pop after it was set; set wins over clear in same cycle.
//  DataOut undefined-free: holds last head value when empty (0 after reset).
//  reset asserted mid-frame: frame abandoned, FIFO contents discarded.
// STRUCTURE
//  Package uart_pkg: FSM state encoding (IDLE,START,DATA,PARITY,STOP), PARITY_NONE/EVEN/ODD.
//  Sub-module rx_fifo (WIDTH=DATA_BITS+2, DEPTH=FIFO_DEPTH): ptr-based, full/empty via
//   extra pointer bit, same reset/clock as parent. Divider, sync, FSM in top.
// TESTING  (bench: CLK_DIV=2, OVERSAMPLE=16, DATA_BITS=8 unless stated)
//  1 8N1 frame 0xA5, DataReady=1 -> DataValid pulse one cycle, DataOut=0xA5, errs 0.
//  2 PARITY=1, send 0x07 with parity bit 0 -> DataOut=0x07, ParityErr=1; correct bit 1 -> 0.
//  3 stop bit driven low, data 0x3C -> DataOut=0x3C, FrameErr=1; STOP_BITS=2, 2nd stop low -> FrameErr=1.
//  4 start glitch low for 4 ticks then high -> Busy returns 0, DataValid stays 0.
//  5 DataReady=0, send 5 frames 0x01..0x05 (DEPTH 4) -> FIFO holds 01..04, Overrun=1;
//    pop all -> 01,02,03,04 in order, Overrun clears after first pop.
//  6 assert reset mid-DATA and with 2 words queued -> all outputs 0 at once; next frame 0x5A
//    received correctly after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the oversampled UART receiver and its word FIFO.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/rx_fifo.sv
// Pointer-based word FIFO with a registered head word that holds its last value when empty.
module rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic             empty, full, do_push, do_pop;

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop  = pop && !empty;
        // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
        do_push = push && (!full || do_pop);
        drop    = push && full && !do_pop;
        valid   = !empty;
        wr_nxt  = wr_ptr + (AW+1)'(do_push);
        rd_nxt  = rd_ptr + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            // Head register tracks the next read slot, taking the incoming word when it lands there.
            if (wr_nxt != rd_nxt)
                rdata <= (do_push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) ? wdata
                                                                        : mem[rd_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver: input sync, start-edge alignment, framing FSM and a word FIFO
// carrying {frame_err, parity_err, data} to a valid/ready consumer.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV     = 300,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 DataIn,
    input  logic                 DataReady,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 DataValid,
    output logic                 ParityErr,
    output logic                 FrameErr,
    output logic                 Overrun,
    output logic                 Busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(DATA_BITS);
    localparam int WW    = DATA_BITS + 2;

    rx_state_t            state;
    logic [1:0]           sync;
    logic                 line, prev;
    logic [DIV_W-1:0]     div;
    logic [SC_W-1:0]      sc;
    logic [BC_W-1:0]      bc;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, ferr;
    logic                 tick, sc_hit, sample, start_edge, last_stop, push, drop;
    logic [WW-1:0]        push_word, head;

    always_comb begin
        line       = sync[1];
        tick       = (div == DIV_W'(CLK_DIV - 1));
        sc_hit     = (state == ST_START) ? (sc == SC_W'(OVERSAMPLE / 2 - 1))
                                         : (sc == SC_W'(OVERSAMPLE - 1));
        sample     = tick && sc_hit && (state != ST_IDLE);
        start_edge = (state == ST_IDLE) && prev && !line;
        last_stop  = (bc == BC_W'(STOP_BITS - 1));
        push       = sample && (state == ST_STOP) && last_stop;
        // The final stop sample is folded in directly so the word is pushed on that same cycle.
        push_word  = {ferr | ~line, perr, shreg};
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync  <= 2'b11;
            prev  <= 1'b1;
            div   <= '0;
            sc    <= '0;
            bc    <= '0;
            shreg <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            state <= ST_IDLE;
        end else begin
            sync <= {sync[0], DataIn};
            prev <= line;
            if (start_edge) begin
                // Restart the tick phase so bit centres line up with the falling edge.
                div   <= '0;
                sc    <= '0;
                bc    <= '0;
                perr  <= 1'b0;
                ferr  <= 1'b0;
                state <= ST_START;
            end else begin
                div <= tick ? '0 : div + DIV_W'(1);
                if (tick && state != ST_IDLE) sc <= sc_hit ? '0 : sc + SC_W'(1);
                if (sample) begin
                    case (state)
                        ST_START: begin
                            bc    <= '0;
                            state <= line ? ST_IDLE : ST_DATA;
                        end
                        ST_DATA: begin
                            shreg <= {line, shreg[DATA_BITS-1:1]};
                            if (bc == BC_W'(DATA_BITS - 1)) begin
                                bc    <= '0;
                                state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                bc <= bc + BC_W'(1);
                            end
                        end
                        ST_PARITY: begin
                            perr  <= (PARITY == PARITY_EVEN || PARITY == PARITY_ODD) &&
                                     (((^shreg) ^ line) != (PARITY == PARITY_ODD));
                            bc    <= '0;
                            state <= ST_STOP;
                        end
                        ST_STOP: begin
                            ferr <= ferr | ~line;
                            if (last_stop) begin
                                bc    <= '0;
                                state <= ST_IDLE;
                            end else begin
                                bc <= bc + BC_W'(1);
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    rx_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .reset (reset),
        .push  (push),
        .wdata (push_word),
        .pop   (DataReady),
        .rdata (head),
        .valid (DataValid),
        .drop  (drop)
    );

    // Sticky overrun: a new drop outranks the clearing pop.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)                      Overrun <= 1'b0;
        else if (drop)                   Overrun <= 1'b1;
        else if (DataValid && DataReady) Overrun <= 1'b0;
    end

    assign {FrameErr, ParityErr, DataOut} = head;
    assign Busy = (state != ST_IDLE);

endmodule
